mc_ctrl: RTL and testbench

- Multicycle control unit for the CPU datapath.
- Sequences FETCH/DECODE/EXEC/MEM/WB and issues one ALU operation per instruction through `alu_op`, using the team's 4-bit ALU encoding.
- Consumes the ALU `zero` flag for `beq`.
- Handshakes with a shared instruction/data memory port that has variable latency.

---
 rtl/cpu_defs.sv | 78 +++++++
 rtl/mc_decode.sv | 79 +++++++
 rtl/mc_ctrl.sv | 156 +++++++++++++++
 tb/tb_mc_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared CPU definitions: ALU codes, opcode/funct constants, FSM states and
// datapath mux encodings used by the multicycle controller and the datapath.
package cpu_defs;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_XOR = 4'b1110,
    ALU_SLL = 4'b1111
  } alu_op_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JUMP   = 2'd2,
    PC_RS     = 2'd3
  } pc_src_e;

  typedef enum logic [1:0] {
    EXT_ZERO  = 2'd0,
    EXT_SIGN  = 2'd1,
    EXT_UPPER = 2'd2
  } ext_op_e;

  typedef enum logic [1:0] {
    DST_RT = 2'd0,
    DST_RD = 2'd1,
    DST_RA = 2'd2
  } reg_dst_e;

  typedef enum logic [1:0] {
    WD_ALU = 2'd0,
    WD_MEM = 2'd1,
    WD_PC  = 2'd2
  } wd_sel_e;

  // Instruction classes decide the state sequence after DECODE.
  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_LW,
    CLS_SW,
    CLS_BEQ,
    CLS_J,
    CLS_JAL,
    CLS_JR,
    CLS_ILLEGAL
  } instr_cls_e;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder: maps the IR to an instruction class and
// the ALU/immediate/destination controls that stay constant for its lifetime.
module mc_decode
  import cpu_defs::*;
(
  input  logic [31:0] instr,
  output instr_cls_e  cls,
  output alu_op_e     alu_op,
  output logic        alu_src_b,
  output ext_op_e     ext_op,
  output reg_dst_e    reg_dst,
  output logic        illegal
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_fields;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];
  // Register numbers and shamt are routed to the datapath directly.
  assign unused_fields = ^instr[25:6];

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    cls       = CLS_ILLEGAL;
    alu_op    = ALU_ADD;
    alu_src_b = 1'b0;
    ext_op    = EXT_ZERO;
    reg_dst   = DST_RT;
    case (opcode)
      OP_RTYPE: begin
        cls     = CLS_ALU;
        reg_dst = DST_RD;
        case (funct)
          FN_ADD, FN_ADDU: alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: alu_op = ALU_SUB;
          FN_AND:          alu_op = ALU_AND;
          FN_OR:           alu_op = ALU_OR;
          FN_XOR:          alu_op = ALU_XOR;
          FN_SLL:          alu_op = ALU_SLL;
          FN_JR:           cls    = CLS_JR;
          default:         cls    = CLS_ILLEGAL;
        endcase
      end
      OP_ORI: begin
        cls       = CLS_ALU;
        alu_op    = ALU_OR;
        alu_src_b = 1'b1;
        ext_op    = EXT_ZERO;
      end
      OP_LUI: begin
        cls       = CLS_ALU;
        alu_op    = ALU_OR;
        alu_src_b = 1'b1;
        ext_op    = EXT_UPPER;
      end
      OP_LW, OP_SW: begin
        cls       = (opcode == OP_LW) ? CLS_LW : CLS_SW;
        alu_src_b = 1'b1;
        ext_op    = EXT_SIGN;
      end
      OP_BEQ: begin
        cls    = CLS_BEQ;
        alu_op = ALU_SUB;
        ext_op = EXT_SIGN;
      end
      OP_J:    cls = CLS_J;
      OP_JAL: begin
        cls     = CLS_JAL;
        reg_dst = DST_RA;
      end
      default: cls = CLS_ILLEGAL;
    endcase
  end

  assign illegal = (cls == CLS_ILLEGAL);

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle CPU control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with a
// variable-latency memory handshake and a retired-instruction counter.
module mc_ctrl
  import cpu_defs::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             ir_we,
  output logic [3:0]       alu_op,
  output logic             alu_src_b,
  output logic [1:0]       ext_op,
  output logic             reg_we,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wd_sel,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_cnt
);

  state_e     state, state_nxt;
  instr_cls_e dec_cls;
  alu_op_e    dec_alu_op;
  logic       dec_alu_src_b;
  ext_op_e    dec_ext_op;
  reg_dst_e   dec_reg_dst;
  logic       dec_illegal;

  mc_decode u_decode (
    .instr     (instr),
    .cls       (dec_cls),
    .alu_op    (dec_alu_op),
    .alu_src_b (dec_alu_src_b),
    .ext_op    (dec_ext_op),
    .reg_dst   (dec_reg_dst),
    .illegal   (dec_illegal)
  );

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= FETCH;
      instr_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state != FETCH && state_nxt == FETCH)
        instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_we        = 1'b0;
    pc_src       = PC_PLUS4;
    ir_we        = 1'b0;
    alu_op       = ALU_ADD;
    alu_src_b    = 1'b0;
    ext_op       = EXT_ZERO;
    reg_we       = 1'b0;
    reg_dst      = DST_RT;
    wd_sel       = WD_ALU;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    illegal      = 1'b0;

    // Per-instruction datapath controls hold steady from DECODE through WB.
    if (state != FETCH) begin
      alu_op    = dec_alu_op;
      alu_src_b = dec_alu_src_b;
      ext_op    = dec_ext_op;
      reg_dst   = dec_reg_dst;
    end

    case (state)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we     = 1'b1;
          pc_we     = 1'b1;
          state_nxt = DECODE;
        end
      end
      DECODE: begin
        if (dec_illegal) begin
          illegal   = 1'b1;
          state_nxt = FETCH;
        end else begin
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        case (dec_cls)
          CLS_ALU:        state_nxt = WB;
          CLS_LW, CLS_SW: state_nxt = MEM;
          CLS_BEQ: begin
            pc_we     = zero;
            pc_src    = PC_BRANCH;
            state_nxt = FETCH;
          end
          CLS_J: begin
            pc_we     = 1'b1;
            pc_src    = PC_JUMP;
            state_nxt = FETCH;
          end
          CLS_JAL: begin
            pc_we     = 1'b1;
            pc_src    = PC_JUMP;
            reg_we    = 1'b1;
            reg_dst   = DST_RA;
            wd_sel    = WD_PC;
            state_nxt = FETCH;
          end
          CLS_JR: begin
            pc_we     = 1'b1;
            pc_src    = PC_RS;
            state_nxt = FETCH;
          end
          default: state_nxt = FETCH;
        endcase
      end
      MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (dec_cls == CLS_SW);
        if (mem_ready)
          state_nxt = (dec_cls == CLS_SW) ? FETCH : WB;
      end
      WB: begin
        reg_we    = 1'b1;
        wd_sel    = (dec_cls == CLS_LW) ? WD_MEM : WD_ALU;
        state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase

    // An access in flight when reset hits is abandoned without side effects.
    if (reset) begin
      pc_we   = 1'b0;
      ir_we   = 1'b0;
      reg_we  = 1'b0;
      mem_we  = 1'b0;
      mem_req = 1'b0;
      illegal = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-instruction expectations are queued before
// each instruction is issued and compared once it retires.
module tb_mc_ctrl;
  import cpu_defs::*;

  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [31:0]      instr;
  logic             zero;
  logic             mem_ready;
  logic             pc_we;
  logic [1:0]       pc_src;
  logic             ir_we;
  logic [3:0]       alu_op;
  logic             alu_src_b;
  logic [1:0]       ext_op;
  logic             reg_we;
  logic [1:0]       reg_dst;
  logic [1:0]       wd_sel;
  logic             mem_req;
  logic             mem_we;
  logic             mem_addr_sel;
  logic             illegal;
  logic [CNT_W-1:0] instr_cnt;

  mc_ctrl #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .instr        (instr),
    .zero         (zero),
    .mem_ready    (mem_ready),
    .pc_we        (pc_we),
    .pc_src       (pc_src),
    .ir_we        (ir_we),
    .alu_op       (alu_op),
    .alu_src_b    (alu_src_b),
    .ext_op       (ext_op),
    .reg_we       (reg_we),
    .reg_dst      (reg_dst),
    .wd_sel       (wd_sel),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .illegal      (illegal),
    .instr_cnt    (instr_cnt)
  );

  always #5 clk = ~clk;

  // -1 in a field means the value is not constrained for that instruction.
  typedef struct {
    int cycles;
    int dec_alu;
    int exec_src;
    int pc_we_n;
    int reg_we_n;
    int rdst;
    int wsel;
    int mem_we_n;
    int ill_n;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   exp_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int cyc, input int alu, input int src, input int pcn,
                      input int rn, input int rd, input int ws, input int mn, input int il);
    exp_t e;
    e.cycles = cyc; e.dec_alu = alu; e.exec_src = src; e.pc_we_n = pcn;
    e.reg_we_n = rn; e.rdst = rd; e.wsel = ws; e.mem_we_n = mn; e.ill_n = il;
    sb.push_back(e);
  endtask

  // Entered and left #1 after a rising edge with the DUT in FETCH.
  task automatic run_instr(input string name, input logic [31:0] word,
                           input int fwait, input int mwait, input logic zv);
    exp_t e, o;
    int cyc, ir_n, ph, fw, mw;
    bit fetched, done, load;
    logic [CNT_W-1:0] cnt0;
    cyc = 0; ir_n = 0; ph = 0; fw = fwait; mw = mwait;
    fetched = 0; done = 0; load = 0;
    o.cycles = 0; o.dec_alu = -1; o.exec_src = -1; o.pc_we_n = 0; o.reg_we_n = 0;
    o.rdst = -1; o.wsel = -1; o.mem_we_n = 0; o.ill_n = 0;
    cnt0 = instr_cnt;
    zero = zv;
    check({name, " fetch_alu"}, 32'(alu_op), 32'(ALU_ADD));
    while (!done && cyc < 60) begin
      if (!fetched)     mem_ready = (fw == 0);
      else if (mem_req) mem_ready = (mw == 0);
      else              mem_ready = 1'b1;
      @(negedge clk);
      load = 0;
      if (ir_we) ir_n++;
      if (!fetched) begin
        if (fw > 0) begin
          check({name, " fetch_hold"}, 32'({ir_we, pc_we, mem_req, mem_addr_sel}), 32'(4'b0010));
          fw--;
        end else begin
          check({name, " fetch_ready"}, 32'({pc_we, pc_src, mem_req, mem_addr_sel}), 32'(5'b1_00_1_0));
          load = 1;
          fetched = 1;
        end
      end else begin
        if (ph == 0) o.dec_alu = int'(alu_op);
        if (ph == 1) o.exec_src = int'(pc_src);
        ph++;
        if (pc_we) o.pc_we_n++;
        if (reg_we) begin
          o.reg_we_n++;
          o.rdst = int'(reg_dst);
          o.wsel = int'(wd_sel);
        end
        if (mem_we) o.mem_we_n++;
        if (illegal) o.ill_n++;
        if (mem_req && !mem_ready) begin
          check({name, " mem_hold"}, 32'({mem_addr_sel, reg_we, pc_we, ir_we, alu_op}),
                32'({4'b1000, ALU_ADD}));
          mw--;
        end
      end
      @(posedge clk);
      #1;
      cyc++;
      if (load) instr = word;
      if (instr_cnt !== cnt0) done = 1;
    end
    check({name, " retired"}, 32'(done), 32'd1);
    if (sb.size() == 0) begin
      check({name, " scoreboard_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      exp_cnt++;
      check({name, " cycles"}, cyc, e.cycles);
      check({name, " ir_we_pulses"}, ir_n, 1);
      check({name, " instr_cnt"}, instr_cnt, exp_cnt);
      if (e.dec_alu >= 0)  check({name, " alu_op"}, o.dec_alu, e.dec_alu);
      if (e.exec_src >= 0) check({name, " exec_pc_src"}, o.exec_src, e.exec_src);
      check({name, " pc_we_exec"}, o.pc_we_n, e.pc_we_n);
      check({name, " reg_we"}, o.reg_we_n, e.reg_we_n);
      if (e.rdst >= 0) check({name, " reg_dst"}, o.rdst, e.rdst);
      if (e.wsel >= 0) check({name, " wd_sel"}, o.wsel, e.wsel);
      check({name, " mem_we"}, o.mem_we_n, e.mem_we_n);
      check({name, " illegal"}, o.ill_n, e.ill_n);
    end
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b1; zero = 1'b0; instr = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset mem_req", 32'(mem_req), 32'd0);
    check("reset ir_pc_we", 32'({ir_we, pc_we}), 32'd0);
    check("reset reg_mem_we_ill", 32'({reg_we, mem_we, illegal}), 32'd0);
    check("reset instr_cnt", instr_cnt, 32'd0);
    @(negedge clk);
    mem_ready = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset fetch", 32'({mem_req, mem_addr_sel, alu_op}), 32'({2'b10, ALU_ADD}));

    // Zero-wait stream: ori, addu, lw, sw, beq taken, j
    push(4, ALU_OR,  -1, 0, 1, DST_RT, WD_ALU, 0, 0); run_instr("ori",  32'h3401_0005, 0, 0, 1'b0);
    push(4, ALU_ADD, -1, 0, 1, DST_RD, WD_ALU, 0, 0); run_instr("addu", 32'h0022_1821, 0, 0, 1'b0);
    push(5, ALU_ADD, -1, 0, 1, DST_RT, WD_MEM, 0, 0); run_instr("lw",   32'h8C04_0000, 0, 0, 1'b0);
    push(4, ALU_ADD, -1, 0, 0, -1, -1, 1, 0);         run_instr("sw",   32'hAC04_0004, 0, 0, 1'b0);
    push(3, ALU_SUB, PC_BRANCH, 1, 0, -1, -1, 0, 0);  run_instr("beq1", 32'h1021_0002, 0, 0, 1'b1);
    push(3, -1, PC_JUMP, 1, 0, -1, -1, 0, 0);         run_instr("j",    32'h0800_0010, 0, 0, 1'b0);
    check("stream instr_cnt", instr_cnt, 32'd6);

    // Memory waits: 3 in FETCH and 2 in MEM
    push(10, ALU_ADD, -1, 0, 1, DST_RT, WD_MEM, 0, 0); run_instr("lw_wait", 32'h8C05_0008, 3, 2, 1'b0);
    push(6,  ALU_ADD, -1, 0, 0, -1, -1, 2, 0);         run_instr("sw_wait", 32'hAC05_000C, 1, 1, 1'b0);

    // Branch both ways, then call/return
    push(3, ALU_SUB, PC_BRANCH, 0, 0, -1, -1, 0, 0);   run_instr("beq0", 32'h1021_0002, 0, 0, 1'b0);
    push(3, ALU_SUB, PC_BRANCH, 1, 0, -1, -1, 0, 0);   run_instr("beq1b", 32'h1021_0002, 0, 0, 1'b1);
    push(3, -1, PC_JUMP, 1, 1, DST_RA, WD_PC, 0, 0);   run_instr("jal",  32'h0C00_0020, 0, 0, 1'b0);
    push(3, -1, PC_RS, 1, 0, -1, -1, 0, 0);            run_instr("jr",   32'h03E0_0008, 0, 0, 1'b0);

    // Remaining ALU encodings and undecodable words
    push(4, ALU_SLL, -1, 0, 1, DST_RD, WD_ALU, 0, 0);  run_instr("sll",  32'h0001_1080, 0, 0, 1'b0);
    push(4, ALU_OR,  -1, 0, 1, DST_RT, WD_ALU, 0, 0);  run_instr("lui",  32'h3C01_1234, 0, 0, 1'b0);
    push(4, ALU_SUB, -1, 0, 1, DST_RD, WD_ALU, 0, 0);  run_instr("sub",  32'h0022_1822, 0, 0, 1'b0);
    push(4, ALU_AND, -1, 0, 1, DST_RD, WD_ALU, 0, 0);  run_instr("and",  32'h0022_1824, 0, 0, 1'b0);
    push(4, ALU_XOR, -1, 0, 1, DST_RD, WD_ALU, 0, 0);  run_instr("xor",  32'h0022_1826, 0, 0, 1'b0);
    push(4, ALU_OR,  -1, 0, 1, DST_RD, WD_ALU, 0, 0);  run_instr("or",   32'h0022_1825, 0, 0, 1'b0);
    push(2, -1, -1, 0, 0, -1, -1, 0, 1);               run_instr("ill_op", 32'hFC00_0000, 0, 0, 1'b0);
    push(2, -1, -1, 0, 0, -1, -1, 0, 1);               run_instr("ill_fn", 32'h0000_003F, 0, 0, 1'b0);

    // Reset during the MEM cycle of a store
    mem_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    instr = 32'hAC06_0010;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("sw_rst in_mem", 32'({mem_req, mem_we, mem_addr_sel}), 32'(3'b111));
    reset = 1'b1;
    #1;
    check("sw_rst mem_drop", 32'({mem_req, mem_we}), 32'd0);
    check("sw_rst we_drop", 32'({pc_we, ir_we, reg_we, illegal}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("sw_rst instr_cnt", instr_cnt, 32'd0);
    check("sw_rst fetch", 32'({mem_req, mem_we, mem_addr_sel, alu_op}), 32'({3'b100, ALU_ADD}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
